// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - multi-cycle right shifter (logical/arithmetic), one bit per clock
// Optional macro SHIFT_RIGHT_ZERO_BYPASS_EN: shamt==0 skips SHIFT and completes in one cycle.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;

  // busy and done are registered alongside state so they track it exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg <= data_in;
            cnt  <= shamt;
            fill <= arith & data_in[WIDTH-1];
            busy <= 1'b1;
`ifdef SHIFT_RIGHT_ZERO_BYPASS_EN
            if (shamt == '0) begin
              result <= data_in;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= {fill, sreg[WIDTH-1:1]};
            cnt  <= cnt - 1'b1;
          end else begin
            result <= sreg;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
